// File: rtl/zeroheti_mem_arbiter_pkg.sv
// Shared types and constants for the instr/data memory port arbiter.
// Latency: n/a (type definitions only).
// Backpressure: n/a.
package zeroheti_pkg;

  // Identifies which host issued a memory transaction.
  typedef enum logic {
    SRC_INSTR = 1'b0,
    SRC_DATA  = 1'b1
  } mem_src_e;

  localparam int unsigned MemArbMaxOutstanding = 2;

  // The round-robin pointer always moves to the source that did not just win.
  function automatic mem_src_e other_src(input mem_src_e src);
    return (src == SRC_INSTR) ? SRC_DATA : SRC_INSTR;
  endfunction

endpackage

// File: rtl/zeroheti_mem_arbiter_if.sv
// Bundle of the instr host, data host and memory-side OBI signals around the arbiter.
// Latency: n/a (wires only).
// Backpressure: gnt on each side; responses are never stalled.
interface zeroheti_mem_arbiter_if #(
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32
);
  localparam int unsigned BeWidth = DataWidth / 8;

  logic                 instr_req_i;
  logic                 instr_gnt_o;
  logic [AddrWidth-1:0] instr_addr_i;
  logic                 instr_rvalid_o;
  logic [DataWidth-1:0] instr_rdata_o;
  logic                 instr_err_o;

  logic                 data_req_i;
  logic                 data_gnt_o;
  logic                 data_we_i;
  logic [BeWidth-1:0]   data_be_i;
  logic [AddrWidth-1:0] data_addr_i;
  logic [DataWidth-1:0] data_wdata_i;
  logic                 data_rvalid_o;
  logic [DataWidth-1:0] data_rdata_o;
  logic                 data_err_o;

  logic                 mem_req_o;
  logic                 mem_we_o;
  logic [BeWidth-1:0]   mem_be_o;
  logic [AddrWidth-1:0] mem_addr_o;
  logic [DataWidth-1:0] mem_wdata_o;
  logic                 mem_gnt_i;
  logic                 mem_rvalid_i;
  logic [DataWidth-1:0] mem_rdata_i;
  logic                 mem_err_i;

  logic                 resp_orphan_o;

  // Arbiter side.
  modport slave (
    input  instr_req_i, instr_addr_i,
    input  data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
    input  mem_gnt_i, mem_rvalid_i, mem_rdata_i, mem_err_i,
    output instr_gnt_o, instr_rvalid_o, instr_rdata_o, instr_err_o,
    output data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o,
    output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
    output resp_orphan_o
  );

  // Environment side: core hosts plus memory.
  modport master (
    output instr_req_i, instr_addr_i,
    output data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
    output mem_gnt_i, mem_rvalid_i, mem_rdata_i, mem_err_i,
    input  instr_gnt_o, instr_rvalid_o, instr_rdata_o, instr_err_o,
    input  data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o,
    input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
    input  resp_orphan_o
  );

endinterface

// File: rtl/zeroheti_mem_arbiter_id_fifo.sv
// Source-ID FIFO recording the issuing host of each outstanding transaction, oldest at head.
// Latency: push visible at head one cycle later; head/full/empty are registered-state views.
// Backpressure: caller must not push when full or pop when empty; push+pop in one cycle allowed.
module zeroheti_id_fifo
  import zeroheti_pkg::*;
#(
  parameter int unsigned Depth = 2
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  input  logic     push_i,
  input  mem_src_e push_src_i,
  input  logic     pop_i,
  output logic     full_o,
  output logic     empty_o,
  output mem_src_e head_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth) + 1;

  mem_src_e        r_mem [Depth];
  logic [PtrW-1:0] r_wr_ptr;
  logic [PtrW-1:0] r_rd_ptr;
  logic [CntW-1:0] r_count;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    if (p == PtrW'(Depth - 1)) return '0;
    return p + 1'b1;
  endfunction

  // Storage write; entries beyond the count are don't-care so no reset is needed.
  always_ff @(posedge clk_i) begin
    if (push_i) r_mem[r_wr_ptr] <= push_src_i;
  end

  // Pointer and occupancy tracking, cleared asynchronously so a reset drops all in-flight IDs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (push_i) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (pop_i)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      if (push_i && !pop_i)      r_count <= r_count + 1'b1;
      else if (!push_i && pop_i) r_count <= r_count - 1'b1;
    end
  end

  assign full_o  = (r_count == CntW'(Depth));
  assign empty_o = (r_count == '0);
  assign head_o  = r_mem[r_rd_ptr];

endmodule

// File: rtl/zeroheti_mem_arbiter.sv
// Round-robin arbiter sharing one memory port between instr and data hosts, routing responses back.
// Latency: request/grant and response routing are combinational (zero cycles).
// Backpressure: mem_gnt_i passes to the winner; mem_req_o dropped while MaxOutstanding are in flight.
module zeroheti_mem_arbiter
  import zeroheti_pkg::*;
#(
  parameter int unsigned MaxOutstanding = MemArbMaxOutstanding,
  parameter int unsigned AddrWidth      = 32,
  parameter int unsigned DataWidth      = 32
) (
  input logic                    clk_i,
  input logic                    rst_ni,
  zeroheti_mem_arbiter_if.slave  bus
);

  localparam int unsigned BeWidth = DataWidth / 8;

  mem_src_e             r_rr_ptr;
  logic                 r_orphan;

  mem_src_e             w_winner;
  logic                 w_any_req;
  logic                 w_mem_req;
  logic                 w_fire;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_pop;
  mem_src_e             w_head;
  logic                 w_mem_we;
  logic [BeWidth-1:0]   w_mem_be;
  logic [AddrWidth-1:0] w_mem_addr;
  logic [DataWidth-1:0] w_mem_wdata;

  // Pick the winner and steer its attributes to memory; a full ID FIFO blocks the request only.
  always_comb begin
    w_any_req   = bus.instr_req_i | bus.data_req_i;
    w_winner    = SRC_INSTR;
    w_mem_we    = 1'b0;
    w_mem_be    = '0;
    w_mem_addr  = '0;
    w_mem_wdata = '0;
    if (bus.instr_req_i && bus.data_req_i) w_winner = r_rr_ptr;
    else if (bus.data_req_i)               w_winner = SRC_DATA;
    if (w_any_req) begin
      if (w_winner == SRC_DATA) begin
        w_mem_we    = bus.data_we_i;
        w_mem_be    = bus.data_be_i;
        w_mem_addr  = bus.data_addr_i;
        w_mem_wdata = bus.data_wdata_i;
      end else begin
        w_mem_be    = '1;
        w_mem_addr  = bus.instr_addr_i;
      end
    end
    w_mem_req = w_any_req & ~w_full;
    w_fire    = w_mem_req & bus.mem_gnt_i;
  end

  assign bus.mem_req_o   = w_mem_req;
  assign bus.mem_we_o    = w_mem_we;
  assign bus.mem_be_o    = w_mem_be;
  assign bus.mem_addr_o  = w_mem_addr;
  assign bus.mem_wdata_o = w_mem_wdata;
  assign bus.instr_gnt_o = w_fire & (w_winner == SRC_INSTR);
  assign bus.data_gnt_o  = w_fire & (w_winner == SRC_DATA);

  // Route a response to the oldest outstanding source; the other host sees all zeros.
  always_comb begin
    w_pop              = bus.mem_rvalid_i & ~w_empty;
    bus.instr_rvalid_o = 1'b0;
    bus.instr_rdata_o  = '0;
    bus.instr_err_o    = 1'b0;
    bus.data_rvalid_o  = 1'b0;
    bus.data_rdata_o   = '0;
    bus.data_err_o     = 1'b0;
    if (w_pop) begin
      if (w_head == SRC_DATA) begin
        bus.data_rvalid_o  = 1'b1;
        bus.data_rdata_o   = bus.mem_rdata_i;
        bus.data_err_o     = bus.mem_err_i;
      end else begin
        bus.instr_rvalid_o = 1'b1;
        bus.instr_rdata_o  = bus.mem_rdata_i;
        bus.instr_err_o    = bus.mem_err_i;
      end
    end
  end

  // Round-robin pointer: favour the other source after every accepted request.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)     r_rr_ptr <= SRC_DATA;
    else if (w_fire) r_rr_ptr <= other_src(w_winner);
  end

  // Sticky flag for responses that arrive with nothing outstanding.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                          r_orphan <= 1'b0;
    else if (bus.mem_rvalid_i && w_empty) r_orphan <= 1'b1;
  end

  assign bus.resp_orphan_o = r_orphan;

  zeroheti_id_fifo #(
    .Depth (MaxOutstanding)
  ) u_id_fifo (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .push_i     (w_fire),
    .push_src_i (w_winner),
    .pop_i      (w_pop),
    .full_o     (w_full),
    .empty_o    (w_empty),
    .head_o     (w_head)
  );

endmodule

// File: tb/tb_zeroheti_mem_arbiter.sv
// Bench for the memory arbiter: directed scenarios then random traffic against a queue-based model.
// Latency: checks combinational outputs 1-2 time units after inputs change, updates model at posedge.
// Backpressure: random mem_gnt_i; hosts hold requests until granted.
module tb_zeroheti_mem_arbiter;
  import zeroheti_pkg::*;

  localparam int MAXO = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  zeroheti_mem_arbiter_if #(.AddrWidth(32), .DataWidth(32)) bus ();

  zeroheti_mem_arbiter #(
    .MaxOutstanding (MAXO),
    .AddrWidth      (32),
    .DataWidth      (32)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  int vectors = 0;
  int errs    = 0;

  // Reference model: issue-order queue of sources (0 instr, 1 data), last winner, sticky orphan.
  bit q[$];
  bit last_data;
  bit m_orphan;
  // DUT grant/response observations from the most recent tick.
  bit obs_ig, obs_dg, obs_iv, obs_dv;
  bit log_g[$];
  bit log_r[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    last_data = 1'b0;
    m_orphan  = 1'b0;
  endtask

  task automatic idle();
    bus.instr_req_i  = 0; bus.instr_addr_i = 0;
    bus.data_req_i   = 0; bus.data_we_i    = 0; bus.data_be_i = 0;
    bus.data_addr_i  = 0; bus.data_wdata_i = 0;
    bus.mem_gnt_i    = 0; bus.mem_rvalid_i = 0; bus.mem_rdata_i = 0; bus.mem_err_i = 0;
  endtask

  // One clock cycle: check every output against the model, then advance the model at the edge.
  task automatic tick();
    bit ir, dr, any, win, ereq, efire, rv, hok, hd;
    logic        ewe;
    logic [3:0]  ebe;
    logic [31:0] ea, ewd, rd;
    #1;
    ir  = bus.instr_req_i;
    dr  = bus.data_req_i;
    rv  = bus.mem_rvalid_i;
    rd  = bus.mem_rdata_i;
    any = ir | dr;
    win = (ir && dr) ? !last_data : dr;
    ereq  = any && (q.size() < MAXO);
    efire = ereq && bus.mem_gnt_i;
    ewe = 0; ebe = 0; ea = 0; ewd = 0;
    if (any && win) begin
      ewe = bus.data_we_i; ebe = bus.data_be_i; ea = bus.data_addr_i; ewd = bus.data_wdata_i;
    end else if (any) begin
      ebe = 4'hF; ea = bus.instr_addr_i;
    end
    hok = rv && (q.size() > 0);
    hd  = hok ? q[0] : 1'b0;
    chk("mem_req",      bus.mem_req_o,      ereq);
    chk("mem_we",       bus.mem_we_o,       ewe);
    chk("mem_be",       bus.mem_be_o,       ebe);
    chk("mem_addr",     bus.mem_addr_o,     ea);
    chk("mem_wdata",    bus.mem_wdata_o,    ewd);
    chk("instr_gnt",    bus.instr_gnt_o,    efire && !win);
    chk("data_gnt",     bus.data_gnt_o,     efire && win);
    chk("instr_rvalid", bus.instr_rvalid_o, hok && !hd);
    chk("instr_rdata",  bus.instr_rdata_o,  (hok && !hd) ? rd : 32'h0);
    chk("instr_err",    bus.instr_err_o,    hok && !hd && bus.mem_err_i);
    chk("data_rvalid",  bus.data_rvalid_o,  hok && hd);
    chk("data_rdata",   bus.data_rdata_o,   (hok && hd) ? rd : 32'h0);
    chk("data_err",     bus.data_err_o,     hok && hd && bus.mem_err_i);
    chk("orphan",       bus.resp_orphan_o,  m_orphan);
    obs_ig = bus.instr_gnt_o;   obs_dg = bus.data_gnt_o;
    obs_iv = bus.instr_rvalid_o; obs_dv = bus.data_rvalid_o;
    @(posedge clk);
    if (hok)     void'(q.pop_front());
    else if (rv) m_orphan = 1'b1;
    if (efire) begin
      q.push_back(win);
      last_data = win;
    end
    #1;
  endtask

  initial begin
    bit ihold, dhold;
    idle();
    model_reset();

    // Reset state, including a response arriving while held in reset.
    bus.mem_rvalid_i = 1; bus.mem_rdata_i = 32'h5555_AAAA;
    #12;
    chk("rst_mem_req",   bus.mem_req_o,      0);
    chk("rst_gnt",       {bus.instr_gnt_o, bus.data_gnt_o}, 0);
    chk("rst_rvalid",    {bus.instr_rvalid_o, bus.data_rvalid_o}, 0);
    chk("rst_rdata",     {bus.instr_rdata_o, bus.data_rdata_o}, 0);
    chk("rst_addr",      bus.mem_addr_o,     0);
    chk("rst_orphan",    bus.resp_orphan_o,  0);
    @(negedge clk);
    chk("rst_orphan_held", bus.resp_orphan_o, 0);
    idle();
    rst_n = 1;
    @(posedge clk); #1;

    // Instr-only fetch, answered one cycle later.
    bus.instr_req_i = 1; bus.instr_addr_i = 32'h0000_0100; bus.mem_gnt_i = 1;
    #1 chk("t1_igrant", bus.instr_gnt_o, 1);
    tick();
    idle(); bus.mem_rvalid_i = 1; bus.mem_rdata_i = 32'hDEAD_BEEF;
    #1 chk("t1_irdata", bus.instr_rdata_o, 32'hDEAD_BEEF);
    chk("t1_dvalid", bus.data_rvalid_o, 0);
    tick();

    // Both hosts requesting for 4 cycles: grants and responses alternate D,I,D,I.
    log_g.delete(); log_r.delete();
    for (int k = 0; k < 5; k++) begin
      idle();
      bus.mem_gnt_i = 1;
      if (k < 4) begin
        bus.instr_req_i = 1; bus.instr_addr_i = 32'h1000 + k;
        bus.data_req_i  = 1; bus.data_addr_i  = 32'h2000 + k;
        bus.data_we_i   = k[0]; bus.data_be_i = 4'h3; bus.data_wdata_i = 32'hC0DE_0000 + k;
      end
      bus.mem_rvalid_i = (k > 0); bus.mem_rdata_i = 32'hA000_0000 + k;
      tick();
      if (k < 4) log_g.push_back(obs_dg);
      if (k > 0) log_r.push_back(obs_dv);
    end
    for (int k = 0; k < 4; k++) begin
      chk("t2_grant_order", log_g[k], (k % 2) == 0);
      chk("t2_resp_order",  log_r[k], (k % 2) == 0);
    end

    // Full FIFO: third request blocked until a response frees a slot, with no same-cycle bypass.
    idle(); bus.data_req_i = 1; bus.data_addr_i = 32'h3000; bus.mem_gnt_i = 1;
    tick(); tick();
    tick();
    #1 chk("t3_blocked", bus.mem_req_o, 0);
    bus.mem_rvalid_i = 1; bus.mem_rdata_i = 32'h1111_2222;
    #1 chk("t3_nobypass", bus.data_gnt_o, 0);
    tick();
    bus.mem_rvalid_i = 0;
    #1 chk("t3_granted", bus.data_gnt_o, 1);
    tick();
    idle(); bus.mem_rvalid_i = 1;
    tick(); tick();

    // Push+pop at count 1, then an errored data response.
    idle(); bus.instr_req_i = 1; bus.instr_addr_i = 32'h4000; bus.mem_gnt_i = 1;
    tick();
    idle(); bus.data_req_i = 1; bus.data_addr_i = 32'h5000; bus.mem_gnt_i = 1;
    bus.mem_rvalid_i = 1; bus.mem_rdata_i = 32'h0000_1234;
    #1 chk("t4_old_src", bus.instr_rvalid_o, 1);
    tick();
    idle(); bus.mem_rvalid_i = 1; bus.mem_err_i = 1; bus.mem_rdata_i = 32'hBAD0_0001;
    #1 chk("t5_derr", bus.data_err_o, 1);
    chk("t5_ierr", bus.instr_err_o, 0);
    tick();

    // Orphan response, then reset with a transaction outstanding.
    idle(); bus.mem_rvalid_i = 1;
    tick();
    idle();
    #1 chk("t6_orphan_set", bus.resp_orphan_o, 1);
    bus.data_req_i = 1; bus.mem_gnt_i = 1;
    tick();
    idle();
    #2 rst_n = 0;
    #1 chk("t6_orphan_rst", bus.resp_orphan_o, 0);
    model_reset();
    @(negedge clk) rst_n = 1;
    @(posedge clk); #1;
    bus.mem_rvalid_i = 1; bus.mem_rdata_i = 32'h7777_7777;
    #1 chk("t6_fifo_empty", {bus.instr_rvalid_o, bus.data_rvalid_o}, 0);
    tick();
    idle();

    // Random traffic; hosts keep a request and its attributes steady until granted.
    ihold = 0; dhold = 0;
    for (int n = 0; n < 400; n++) begin
      if (!ihold) begin
        bus.instr_req_i  = ($urandom_range(0, 2) != 0);
        bus.instr_addr_i = $urandom;
      end
      if (!dhold) begin
        bus.data_req_i   = ($urandom_range(0, 2) != 0);
        bus.data_we_i    = $urandom_range(0, 1);
        bus.data_be_i    = 4'($urandom);
        bus.data_addr_i  = $urandom;
        bus.data_wdata_i = $urandom;
      end
      bus.mem_gnt_i    = ($urandom_range(0, 3) != 0);
      bus.mem_rvalid_i = (q.size() > 0) && ($urandom_range(0, 1) == 1);
      bus.mem_rdata_i  = $urandom;
      bus.mem_err_i    = ($urandom_range(0, 7) == 0);
      tick();
      ihold = bus.instr_req_i && !obs_ig;
      dhold = bus.data_req_i && !obs_dg;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
